// File: rtl/cache_tagarray_nway.sv
`default_nettype none
// ============================================================================
//  Module      : cache_tagarray_nway
//  Description : N-way set-associative tag store holding {valid,dirty,tag}
//                per way per set. Registered lookup with tag compare, hit/way
//                detection and tree-PLRU victim selection. A sweep FSM clears
//                every set after reset before requests are accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_tagarray_nway #(
    parameter int WAYS       = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int TAG_WIDTH  = 36
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  ready,
    input  logic                  lkp_valid,
    input  logic [ADDR_WIDTH-1:0] lkp_index,
    input  logic [TAG_WIDTH-1:0]  lkp_tag,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [WAYS-1:0]       rsp_way,
    output logic                  rsp_dirty,
    output logic [WAYS-1:0]       rsp_victim,
    output logic [TAG_WIDTH-1:0]  rsp_victim_tag,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_index,
    input  logic [WAYS-1:0]       wr_way,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic                  wr_valid,
    input  logic                  wr_dirty
);

    localparam int c_sets   = 2 ** ADDR_WIDTH;
    localparam int c_levels = $clog2(WAYS);
    localparam logic [ADDR_WIDTH-1:0] c_last_set = '1;
    localparam logic [WAYS-1:0]       c_way_one  = {{(WAYS-1){1'b0}}, 1'b1};
    localparam logic [WAYS-2:0]       c_bit_one  = {{(WAYS-2){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ctr;
    logic [ADDR_WIDTH-1:0]   w_ctr_nxt;
    logic                    w_ready;

    // Storage, one packed bit-vector per way for state bits
    logic [c_sets-1:0]       r_valid [WAYS];
    logic [c_sets-1:0]       r_dirty [WAYS];
    logic [TAG_WIDTH-1:0]    r_tag   [WAYS][c_sets];
    logic [WAYS-2:0]         r_plru  [c_sets];

    logic                    w_lkp_go;
    logic                    w_wr_go;
    logic [WAYS-1:0]         w_set_valid;
    logic [WAYS-1:0]         w_set_dirty;
    logic [WAYS-1:0]         w_hit;
    logic                    w_hit_any;
    logic [WAYS-1:0]         w_inv;
    logic [WAYS-1:0]         w_first_inv;
    logic [WAYS-1:0]         w_victim;
    logic [TAG_WIDTH-1:0]    w_vtag_acc [WAYS];
    logic                    w_dirty_sel;
    logic [WAYS-2:0]         w_plru_hit;
    logic [WAYS-2:0]         w_plru_wr;

    // Walk the tree from the root; a bit value of 1 sends the victim right
    function automatic logic [WAYS-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int              node;
        logic [WAYS-2:0] sh;
        node = 0;
        for (int l = 0; l < c_levels; l++) begin
            sh   = bits >> node;
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        plru_victim = c_way_one << (node - (WAYS - 1));
    endfunction

    // Make every node on the path to the touched way point away from it
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAYS-1:0] way);
        int              wi;
        int              node;
        int              dir;
        logic [WAYS-1:0] sh;
        logic [WAYS-2:0] res;
        wi  = 0;
        res = bits;
        for (int w = 0; w < WAYS; w++) begin
            sh = way >> w;
            if (sh[0]) wi = w;
        end
        node = 0;
        for (int l = 0; l < c_levels; l++) begin
            dir = (wi >> (c_levels - 1 - l)) & 1;
            if (dir == 0) res = res | (c_bit_one << node);
            else          res = res & ~(c_bit_one << node);
            node = 2 * node + 1 + dir;
        end
        plru_touch = res;
    endfunction

    // Sweep/run state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_ctr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
        end
    end

    // Sweep sequencing: one set cleared per cycle, then run forever
    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr;
        w_ready     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_ctr_nxt = r_ctr + 1'b1;
                if (r_ctr == c_last_set) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_ready = 1'b1;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign ready    = w_ready;
    assign w_lkp_go = lkp_valid && w_ready;
    assign w_wr_go  = wr_en && w_ready;

    genvar gw;
    generate
        for (gw = 0; gw < WAYS; gw++) begin : g_way
            assign w_set_valid[gw] = r_valid[gw][lkp_index];
            assign w_set_dirty[gw] = r_dirty[gw][lkp_index];
            assign w_hit[gw]       = w_set_valid[gw] && (r_tag[gw][lkp_index] == lkp_tag);

            if (gw == 0) begin : g_first
                assign w_vtag_acc[gw] = {TAG_WIDTH{w_victim[gw]}} & r_tag[gw][lkp_index];
            end else begin : g_rest
                assign w_vtag_acc[gw] = w_vtag_acc[gw-1]
                                      | ({TAG_WIDTH{w_victim[gw]}} & r_tag[gw][lkp_index]);
            end

            // Per-way entry: cleared by the sweep, written by wr_en; dirty only survives with valid
            always_ff @(posedge clock) begin
                if (reset_n) begin
                    if (r_state == ST_INIT) begin
                        r_valid[gw][r_ctr] <= 1'b0;
                        r_dirty[gw][r_ctr] <= 1'b0;
                        r_tag[gw][r_ctr]   <= '0;
                    end else if (w_wr_go && wr_way[gw]) begin
                        r_valid[gw][wr_index] <= wr_valid;
                        r_dirty[gw][wr_index] <= wr_valid && wr_dirty;
                        r_tag[gw][wr_index]   <= wr_tag;
                    end
                end
            end
        end
    endgenerate

    assign w_hit_any   = |w_hit;
    assign w_inv       = ~w_set_valid;
    assign w_first_inv = w_inv & (~w_inv + c_way_one);
    assign w_victim    = (|w_inv) ? w_first_inv : plru_victim(r_plru[lkp_index]);
    assign w_dirty_sel = w_hit_any ? |(w_hit & w_set_dirty) : |(w_victim & w_set_dirty);
    assign w_plru_hit  = plru_touch(r_plru[lkp_index], w_hit);
    assign w_plru_wr   = plru_touch(r_plru[wr_index], wr_way);

    // PLRU bits: sweep clears, hit updates, a valid write to the same set overrides the hit
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (r_state == ST_INIT) begin
                r_plru[r_ctr] <= '0;
            end else begin
                if (w_lkp_go && w_hit_any) r_plru[lkp_index] <= w_plru_hit;
                if (w_wr_go && wr_valid && (|wr_way)) r_plru[wr_index] <= w_plru_wr;
            end
        end
    end

    // Lookup response register, captured from the pre-write snapshot
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_valid      <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_way        <= '0;
            rsp_dirty      <= 1'b0;
            rsp_victim     <= '0;
            rsp_victim_tag <= '0;
        end else begin
            rsp_valid <= w_lkp_go;
            if (w_lkp_go) begin
                rsp_hit        <= w_hit_any;
                rsp_way        <= w_hit;
                rsp_dirty      <= w_dirty_sel;
                rsp_victim     <= w_victim;
                rsp_victim_tag <= w_vtag_acc[WAYS-1];
            end
        end
    end

    a_single_hit : assert property (@(posedge clock) disable iff (!reset_n)
        w_lkp_go |-> $onehot0(w_hit));
    a_wr_onehot : assert property (@(posedge clock) disable iff (!reset_n)
        w_wr_go |-> $onehot0(wr_way));

endmodule
`default_nettype wire
